// File: rtl/univ_shift_reg_pkg.sv
// rtl/univ_shift_reg_pkg.sv - mode/state types and shift-mode predicate; rotate modes gated by UNIV_SHIFT_REG_ROTATE_EN
package univ_shift_reg_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_CLR  = 3'b100,
        MODE_ROTL = 3'b101,
        MODE_ROTR = 3'b110,
        MODE_RSVD = 3'b111
    } mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // True for the modes a burst may repeat; rotates only exist when enabled.
    function automatic logic is_shift_mode(input mode_t m);
        logic r;
        r = (m == MODE_SHL) || (m == MODE_SHR);
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        r = r || (m == MODE_ROTL) || (m == MODE_ROTR);
`endif
        return r;
    endfunction

endpackage

// File: rtl/univ_shift_reg_shift_burst_ctl.sv
// rtl/univ_shift_reg_shift_burst_ctl.sv - IDLE/BUSY burst engine: count latch, remaining counter, busy/done, latched mode
module shift_burst_ctl
    import univ_shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  mode_t            mode_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] count_i,
    output mode_t            op_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    state_t           state_q, state_d;
    mode_t            mode_q, mode_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] count_sat;

    assign count_sat = (count_i > WIDTH_C) ? WIDTH_C : count_i;

    // Next-state and the op applied to q on this edge.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        op_o    = mode_i;
        case (state_q)
            ST_IDLE: begin
                if (start_i && is_shift_mode(mode_i)) begin
                    if (count_sat == '0) begin
                        // Empty burst: leave q alone but still acknowledge it.
                        op_o   = MODE_HOLD;
                        done_d = 1'b1;
                    end else begin
                        mode_d = mode_i;
                        rem_d  = count_sat - ONE_C;
                        if (count_sat == ONE_C) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = ST_BUSY;
                        end
                    end
                end
            end
            ST_BUSY: begin
                op_o  = mode_q;
                rem_d = rem_q - ONE_C;
                if (rem_q == ONE_C) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Burst engine registers; reset discards any burst in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_HOLD;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    assign busy_o = (state_q == ST_BUSY);
    assign done_o = done_q;

endmodule

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register top with burst engine; rotate modes via UNIV_SHIFT_REG_ROTATE_EN
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [2:0]       mode_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             sin_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] count_i,
    output logic [WIDTH-1:0] q_o,
    output logic             sout_o,
    output logic             busy_o,
    output logic             done_o
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             dir_left_q, dir_left_d;
    mode_t            op;

    shift_burst_ctl #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_ctl (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .mode_i  (mode_t'(mode_i)),
        .start_i (start_i),
        .count_i (count_i),
        .op_o    (op),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    // Op mux; direction flag only moves on shifts/rotates.
    always_comb begin
        q_d        = q_q;
        dir_left_d = dir_left_q;
        case (op)
            MODE_LOAD: q_d = d_i;
            MODE_SHL: begin
                q_d        = {q_q[WIDTH-2:0], sin_i};
                dir_left_d = 1'b1;
            end
            MODE_SHR: begin
                q_d        = {sin_i, q_q[WIDTH-1:1]};
                dir_left_d = 1'b0;
            end
            MODE_CLR: q_d = '0;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
            MODE_ROTL: begin
                q_d        = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                dir_left_d = 1'b1;
            end
            MODE_ROTR: begin
                q_d        = {q_q[0], q_q[WIDTH-1:1]};
                dir_left_d = 1'b0;
            end
`endif
            default: begin
                q_d = q_q;
            end
        endcase
    end

    // Data register and direction flag; reset direction is rightward.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q        <= RESET_VAL;
            dir_left_q <= 1'b0;
        end else begin
            q_q        <= q_d;
            dir_left_q <= dir_left_d;
        end
    end

    assign q_o    = q_q;
    assign sout_o = dir_left_q ? q_q[WIDTH-1] : q_q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - randomized self-checking bench for univ_shift_reg against a behavioural model
module tb_univ_shift_reg;

    localparam int             W  = 8;
    localparam logic [W-1:0]   RV = 8'hA5;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [2:0]   mode = 3'd0;
    logic [W-1:0] d = '0;
    logic         sin = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   count = 4'd0;
    logic [W-1:0] q;
    logic         sout, busy, done;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_q;
    bit           m_left;

    univ_shift_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .mode_i  (mode),
        .d_i     (d),
        .sin_i   (sin),
        .start_i (start),
        .count_i (count),
        .q_o     (q),
        .sout_o  (sout),
        .busy_o  (busy),
        .done_o  (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_apply(input logic [2:0] m, input logic [W-1:0] dv, input logic s);
        case (m)
            3'd1: m_q = dv;
            3'd2: begin m_q = (m_q << 1) | W'(s); m_left = 1'b1; end
            3'd3: begin m_q = (m_q >> 1) | (W'(s) << (W - 1)); m_left = 1'b0; end
            3'd4: m_q = '0;
            3'd5: if (ROT_EN) begin m_q = (m_q << 1) | (m_q >> (W - 1)); m_left = 1'b1; end
            3'd6: if (ROT_EN) begin m_q = (m_q >> 1) | (m_q << (W - 1)); m_left = 1'b0; end
            default: m_q = m_q;
        endcase
    endtask

    function automatic logic exp_sout();
        return m_left ? m_q[W-1] : m_q[0];
    endfunction

    task automatic test_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        m_q = RV;
        m_left = 1'b0;
        checks++; if (q !== 8'hA5) begin errors++; $display("FAIL reset_q got=%h exp=a5", q); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (sout !== 1'b1) begin errors++; $display("FAIL reset_sout got=%b exp=1", sout); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_load_shift();
        mode = 3'd1; d = 8'h3C; start = 1'b0; sin = 1'b0;
        tick();
        model_apply(3'd1, 8'h3C, 1'b0);
        checks++; if (q !== 8'h3C) begin errors++; $display("FAIL load_q got=%h exp=3c", q); end
        mode = 3'd2; sin = 1'b1;
        tick();
        model_apply(3'd2, d, 1'b1);
        checks++; if (q !== 8'h79) begin errors++; $display("FAIL shl_q got=%h exp=79", q); end
        checks++; if (sout !== 1'b0) begin errors++; $display("FAIL shl_sout got=%b exp=0", sout); end
        mode = 3'd3; sin = 1'b0;
        tick();
        model_apply(3'd3, d, 1'b0);
        checks++; if (q !== 8'h3C) begin errors++; $display("FAIL shr_q got=%h exp=3c", q); end
        checks++; if (sout !== 1'b0) begin errors++; $display("FAIL shr_sout got=%b exp=0", sout); end
        mode = 3'd0;
    endtask

    task automatic test_immediate(input int reps);
        for (int i = 0; i < reps; i++) begin
            mode = 3'($urandom_range(0, 7)); d = W'($urandom); sin = 1'($urandom); start = 1'b0;
            model_apply(mode, d, sin);
            tick();
            checks++; if (q !== m_q) begin errors++; $display("FAIL imm_q mode=%0d got=%h exp=%h", mode, q, m_q); end
            checks++; if (sout !== exp_sout()) begin errors++; $display("FAIL imm_sout got=%b exp=%b", sout, exp_sout()); end
            checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL imm_flags busy=%b done=%b exp=0/0", busy, done); end
        end
        mode = 3'd0;
    endtask

    task automatic test_burst(input logic [2:0] bm, input logic [3:0] bc, input logic [W-1:0] init,
                              input bit do_load, input bit tail);
        bit accept;
        int n;
        int busy_seen;
        if (do_load) begin
            mode = 3'd1; d = init; start = 1'b0;
            tick();
            model_apply(3'd1, init, 1'b0);
        end
        accept = (bm == 3'd2) || (bm == 3'd3) || (ROT_EN && (bm == 3'd5 || bm == 3'd6));
        n = (int'(bc) > W) ? W : int'(bc);
        busy_seen = 0;
        mode = bm; count = bc; start = 1'b1; d = W'($urandom);
        if (!accept) begin
            sin = 1'($urandom);
            model_apply(bm, d, sin);
            tick();
            checks++; if (q !== m_q) begin errors++; $display("FAIL nob_q mode=%0d got=%h exp=%h", bm, q, m_q); end
            checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL nob_flags busy=%b done=%b exp=0/0", busy, done); end
        end else if (n == 0) begin
            sin = 1'($urandom);
            tick();
            checks++; if (q !== m_q) begin errors++; $display("FAIL cnt0_q got=%h exp=%h", q, m_q); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cnt0_busy got=%b exp=0", busy); end
            checks++; if (done !== 1'b1) begin errors++; $display("FAIL cnt0_done got=%b exp=1", done); end
        end else begin
            for (int j = 0; j < n; j++) begin
                if (j > 0) begin
                    mode = 3'($urandom_range(0, 7)); d = W'($urandom); start = 1'($urandom);
                    count = 4'($urandom);
                end
                sin = 1'($urandom);
                model_apply(bm, d, sin);
                tick();
                if (busy === 1'b1) busy_seen++;
                checks++; if (q !== m_q) begin errors++; $display("FAIL burst_q mode=%0d step=%0d got=%h exp=%h", bm, j, q, m_q); end
                checks++; if (sout !== exp_sout()) begin errors++; $display("FAIL burst_sout step=%0d got=%b exp=%b", j, sout, exp_sout()); end
                checks++; if (busy !== (j < n - 1)) begin errors++; $display("FAIL burst_busy step=%0d got=%b exp=%b", j, busy, (j < n - 1)); end
                checks++; if (done !== (j == n - 1)) begin errors++; $display("FAIL burst_done step=%0d got=%b exp=%b", j, done, (j == n - 1)); end
            end
            checks++; if (busy_seen != n - 1) begin errors++; $display("FAIL burst_busy_cycles got=%0d exp=%0d", busy_seen, n - 1); end
        end
        start = 1'b0; mode = 3'd0;
        if (tail) begin
            tick();
            checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL tail_flags busy=%b done=%b exp=0/0", busy, done); end
            checks++; if (q !== m_q) begin errors++; $display("FAIL tail_q got=%h exp=%h", q, m_q); end
        end
    endtask

    task automatic test_burst_rotl();
        test_burst(3'd5, 4'd3, 8'h81, 1'b1, 1'b1);
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        checks++; if (q !== 8'h0C) begin errors++; $display("FAIL rotl3_q got=%h exp=0c", q); end
`else
        checks++; if (q !== 8'h81) begin errors++; $display("FAIL rot_off_q got=%h exp=81", q); end
`endif
    endtask

    task automatic test_boundaries();
        logic [W-1:0] r;
        test_burst(3'd2, 4'd0, W'($urandom), 1'b1, 1'b1);
        r = W'($urandom);
        test_burst(3'd6, 4'd12, r, 1'b1, 1'b1);
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        checks++; if (q !== r) begin errors++; $display("FAIL rotr12_q got=%h exp=%h", q, r); end
`else
        checks++; if (q !== r) begin errors++; $display("FAIL rotr_off_q got=%h exp=%h", q, r); end
`endif
        test_burst(3'd2, 4'd12, W'($urandom), 1'b1, 1'b1);
        test_burst(3'd3, 4'd1, W'($urandom), 1'b1, 1'b1);
    endtask

    task automatic test_reset_midburst();
        mode = 3'd1; d = 8'h5A; start = 1'b0;
        tick();
        model_apply(3'd1, 8'h5A, 1'b0);
        mode = 3'd3; count = 4'd6; start = 1'b1;
        sin = 1'($urandom);
        tick();
        start = 1'b0; mode = 3'd0; sin = 1'($urandom);
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got=%b exp=1", busy); end
        #2;
        rst = 1'b1;
        #1;
        m_q = RV; m_left = 1'b0;
        checks++; if (q !== RV) begin errors++; $display("FAIL mid_rst_q got=%h exp=%h", q, RV); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
        checks++; if (sout !== RV[0]) begin errors++; $display("FAIL mid_rst_sout got=%b exp=%b", sout, RV[0]); end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL post_rst_flags busy=%b done=%b exp=0/0", busy, done); end
            checks++; if (q !== RV) begin errors++; $display("FAIL post_rst_q got=%h exp=%h", q, RV); end
        end
        test_burst(3'd3, 4'd4, '0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        test_burst(3'd2, 4'd2, W'($urandom), 1'b1, 1'b0);
        test_burst(3'd3, 4'd3, '0, 1'b0, 1'b0);
        test_burst(3'd2, 4'd1, '0, 1'b0, 1'b0);
        test_burst(3'd5, 4'd2, '0, 1'b0, 1'b1);
    endtask

    task automatic test_random_bursts(input int reps);
        for (int i = 0; i < reps; i++) begin
            test_burst(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), W'($urandom),
                       1'($urandom), 1'($urandom));
        end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand_end_busy got=%b exp=0", busy); end
    endtask

    initial begin
        m_q = '0;
        m_left = 1'b0;
        test_reset();
        test_load_shift();
        test_burst_rotl();
        test_boundaries();
        test_reset_midburst();
        test_back_to_back();
        test_immediate(24);
        test_random_bursts(16);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
